// File: rtl/i2s_stereo_transmitter_if.sv
// Sample handshake bundle between the audio mixer and the I2S transmitter.
//   sample_left  : left channel sample, two's complement (master -> slave)
//   sample_right : right channel sample, two's complement (master -> slave)
//   sample_valid : a sample pair is offered (master -> slave)
//   sample_ready : holding buffer empty; transfer on valid && ready (slave -> master)
interface i2s_stereo_transmitter_if #(
    parameter int unsigned SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] sample_left;
    logic [SAMPLE_WIDTH-1:0] sample_right;
    logic                    sample_valid;
    logic                    sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_stereo_transmitter.sv
// Stereo I2S master transmitter. Generates BCLK/LRCLK from the system clock,
// buffers one stereo pair behind a valid/ready handshake and shifts each
// frame out MSB-first with standard I2S one-bit data delay.
//
// Ports:
//   clk        : system clock, all logic on the rising edge
//   reset      : asynchronous active-high reset
//   smp        : sample handshake (i2s_stereo_transmitter_if.slave)
//   i2s_bclk   : bit clock, period 2*BCLK_DIV clk
//   i2s_lrclk  : word select, 0 = left, 1 = right
//   i2s_sdata  : serial data, changes only on BCLK falling edges
//   underrun   : one-clk pulse when a frame starts with an empty buffer
//
// Optional feature macro: I2S_TX_REPEAT_ON_UNDERRUN_EN
//   defined   : an underrun frame repeats the last loaded pair
//   undefined : an underrun frame transmits silence
module i2s_stereo_transmitter #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned SLOT_WIDTH   = 16,
    parameter int unsigned BCLK_DIV     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    i2s_stereo_transmitter_if.slave        smp,
    output logic                           i2s_bclk,
    output logic                           i2s_lrclk,
    output logic                           i2s_sdata,
    output logic                           underrun
);

    localparam int unsigned FRAME_WIDTH = 2 * SLOT_WIDTH;
    localparam int unsigned PAD_WIDTH   = SLOT_WIDTH - SAMPLE_WIDTH;
    localparam int unsigned CNT_WIDTH   = $clog2(FRAME_WIDTH);
    localparam int unsigned DIV_WIDTH   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(BCLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] LR_FIRST = CNT_WIDTH'(SLOT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] LR_LAST  = CNT_WIDTH'(FRAME_WIDTH - 2);

    logic [DIV_WIDTH-1:0]    divCnt;
    logic [CNT_WIDTH-1:0]    bitCnt;
    logic                    holdEmpty;
    logic [SAMPLE_WIDTH-1:0] holdLeft;
    logic [SAMPLE_WIDTH-1:0] holdRight;
    logic [FRAME_WIDTH-1:0]  frameReg;

    logic                    divWrap;
    logic                    fallEvent;
    logic                    frameStart;
    logic [CNT_WIDTH-1:0]    bitCntNext;
    logic [SLOT_WIDTH-1:0]   slotLeft;
    logic [SLOT_WIDTH-1:0]   slotRight;
    logic [FRAME_WIDTH-1:0]  frameNext;
    logic                    lrclkNext;

    // Ready is the registered buffer-empty flag itself.
    assign smp.sample_ready = holdEmpty;

    // Bit-clock timing, frame boundary detection and next frame contents.
    always_comb begin
        divWrap    = (divCnt == DIV_LAST);
        fallEvent  = divWrap && i2s_bclk;
        frameStart = fallEvent && (bitCnt == CNT_LAST);
        bitCntNext = (bitCnt == CNT_LAST) ? '0 : CNT_WIDTH'(bitCnt + 1'b1);

        // MSB-justify each sample in its slot; low pad bits are zero.
        slotLeft  = SLOT_WIDTH'(holdLeft) << PAD_WIDTH;
        slotRight = SLOT_WIDTH'(holdRight) << PAD_WIDTH;

        frameNext = frameReg;
        if (frameStart) begin
            if (!holdEmpty) begin
                frameNext = {slotLeft, slotRight};
            end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                // frameReg only ever holds real pairs (or reset zeros) here.
                frameNext = frameReg;
`else
                frameNext = '0;
`endif
            end
        end

        // Word select switches one bit before the slot it names.
        lrclkNext = (bitCntNext >= LR_FIRST) && (bitCntNext <= LR_LAST);
    end

    // Divider, serialiser, holding buffer and underrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt    <= '0;
            bitCnt    <= CNT_LAST;
            holdEmpty <= 1'b1;
            holdLeft  <= '0;
            holdRight <= '0;
            frameReg  <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (divWrap) begin
                divCnt   <= '0;
                i2s_bclk <= ~i2s_bclk;
            end else begin
                divCnt <= DIV_WIDTH'(divCnt + 1'b1);
            end

            if (fallEvent) begin
                bitCnt    <= bitCntNext;
                i2s_sdata <= frameNext[CNT_LAST - bitCntNext];
                i2s_lrclk <= lrclkNext;
            end

            if (frameStart) begin
                frameReg <= frameNext;
                if (!holdEmpty) begin
                    holdEmpty <= 1'b1;
                end else begin
                    underrun <= 1'b1;
                end
            end

            // Accept uses the pre-edge empty flag, so a pair taken at an
            // empty frame start waits for the following frame.
            if (smp.sample_valid && holdEmpty) begin
                holdLeft  <= smp.sample_left;
                holdRight <= smp.sample_right;
                holdEmpty <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_stereo_transmitter.sv
// Bench for i2s_stereo_transmitter: a default-parameter instance (16/16/2)
// and a 12-bit-sample instance (12/16/2) run in lock-step on the same
// stimulus. A negedge monitor predicts every output each clk from a clock
// count and a queue of expected frames pushed at each accepted handshake.
module tb_i2s_stereo_transmitter;

    localparam int DIV  = 2;
    localparam int SLOT = 16;

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic [31:0] expA;
        logic [31:0] expB;
        int          gap;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic bclkA, lrA, sdA, urA;
    logic bclkB, lrB, sdB, urB;

    int checks = 0;
    int errors = 0;
    int tbCnt;
    int underCnt = 0;

    logic [31:0] drvA = '0;
    logic [31:0] drvB = '0;

    exp_t        sbq[$];
    exp_t        pend;
    exp_t        popped;
    bit          pendAcc = 1'b0;
    logic [31:0] curA = '0;
    logic [31:0] curB = '0;
    logic [31:0] obsA = '0;
    logic [31:0] obsB = '0;

    i2s_stereo_transmitter_if #(.SAMPLE_WIDTH(16)) ifA ();
    i2s_stereo_transmitter_if #(.SAMPLE_WIDTH(12)) ifB ();

    i2s_stereo_transmitter dutA (
        .clk       (clk),
        .reset     (reset),
        .smp       (ifA),
        .i2s_bclk  (bclkA),
        .i2s_lrclk (lrA),
        .i2s_sdata (sdA),
        .underrun  (urA)
    );

    i2s_stereo_transmitter #(
        .SAMPLE_WIDTH (12),
        .SLOT_WIDTH   (16),
        .BCLK_DIV     (2)
    ) dutB (
        .clk       (clk),
        .reset     (reset),
        .smp       (ifB),
        .i2s_bclk  (bclkB),
        .i2s_lrclk (lrB),
        .i2s_sdata (sdB),
        .underrun  (urB)
    );

    always #5 clk = ~clk;

    // Clk edges since reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tbCnt <= 0;
        else       tbCnt <= tbCnt + 1;
    end

    task automatic chkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d, t=%0t)", name, act, exp, tbCnt, $time);
        end
    endtask

    task automatic chkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d, t=%0t)", name, act, exp, tbCnt, $time);
        end
    endtask

    // Output prediction, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        int   m;
        int   bitIdx;
        logic fs;
        logic expUr;
        logic expLr;
        logic expSdA;
        logic expSdB;
        logic expBclk;
        logic [4:0] sel;

        if (reset || tbCnt == 0) begin
            sbq.delete();
            curA = '0;
            curB = '0;
            chkBit("rstBclkA", bclkA, 1'b0);
            chkBit("rstLrA", lrA, 1'b0);
            chkBit("rstSdA", sdA, 1'b0);
            chkBit("rstUrA", urA, 1'b0);
            chkBit("rstReadyA", ifA.sample_ready, 1'b1);
            chkBit("rstSdB", sdB, 1'b0);
            chkBit("rstReadyB", ifB.sample_ready, 1'b1);
        end else begin
            fs = (tbCnt % (2 * DIV) == 0) && (((tbCnt / (2 * DIV)) - 1) % (2 * SLOT) == 0);
            expUr = 1'b0;
            if (fs) begin
                if (sbq.size() > 0) begin
                    popped = sbq.pop_front();
                    curA = popped.a;
                    curB = popped.b;
                end else begin
                    expUr = 1'b1;
`ifndef I2S_TX_REPEAT_ON_UNDERRUN_EN
                    curA = '0;
                    curB = '0;
`endif
                end
            end
            if (pendAcc) sbq.push_back(pend);

            m = tbCnt / (2 * DIV);
            expBclk = ((tbCnt / DIV) % 2) == 1;
            if (m == 0) begin
                expLr  = 1'b0;
                expSdA = 1'b0;
                expSdB = 1'b0;
            end else begin
                bitIdx = (m - 1) % (2 * SLOT);
                sel    = 5'(31 - bitIdx);
                expSdA = curA[sel];
                expSdB = curB[sel];
                expLr  = (bitIdx >= SLOT - 1) && (bitIdx <= 2 * SLOT - 2);
                obsA[sel] = sdA;
                obsB[sel] = sdB;
                if (bitIdx == 2 * SLOT - 1 && (tbCnt % (2 * DIV)) == 2 * DIV - 1) begin
                    chkWord("frameA", obsA, curA);
                    chkWord("frameB", obsB, curB);
                end
            end

            chkBit("bclkA", bclkA, expBclk);
            chkBit("bclkB", bclkB, expBclk);
            chkBit("lrclkA", lrA, expLr);
            chkBit("lrclkB", lrB, expLr);
            chkBit("sdataA", sdA, expSdA);
            chkBit("sdataB", sdB, expSdB);
            chkBit("underrunA", urA, expUr);
            chkBit("underrunB", urB, expUr);
            chkBit("readyA", ifA.sample_ready, sbq.size() == 0);
            chkBit("readyB", ifB.sample_ready, sbq.size() == 0);
            if (urA) underCnt++;
        end

        // Handshake seen now completes at the next rising edge.
        pendAcc = !reset && ifA.sample_valid && ifA.sample_ready;
        pend.a  = drvA;
        pend.b  = drvB;
    end

    task automatic doReset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        ifA.sample_valid = 1'b0;
        ifB.sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitCnt(input int target);
        for (int k = 0; k < 2000; k++) begin
            if (tbCnt == target) break;
            @(posedge clk);
            #1;
        end
        chkBit("waitCnt", tbCnt == target, 1'b1);
    endtask

    // Offer one pair, wait for it to be taken, optionally keep valid high.
    task automatic offer(input logic [15:0] l, input logic [15:0] r,
                         input logic [31:0] ea, input logic [31:0] eb, input bit keepValid);
        bit ok = 1'b0;
        ifA.sample_left  = l;
        ifA.sample_right = r;
        ifB.sample_left  = l[15:4];
        ifB.sample_right = r[15:4];
        drvA = ea;
        drvB = eb;
        ifA.sample_valid = 1'b1;
        ifB.sample_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ifA.sample_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chkBit("acceptTimeout", ok, 1'b1);
        @(posedge clk);
        #1;
        if (!keepValid) begin
            ifA.sample_valid = 1'b0;
            ifB.sample_valid = 1'b0;
        end
    endtask

    vec_t tab[6];

    initial begin : stim
        int base;

        tab[0] = '{16'hA5F0, 16'h0001, 32'hA5F0_0001, 32'hA5F0_0000, 0};
        tab[1] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000, 32'hFFF0_0000, 0};
        tab[2] = '{16'h0000, 16'hFFFF, 32'h0000_FFFF, 32'h0000_FFF0, 0};
        tab[3] = '{16'h8000, 16'h7FFF, 32'h8000_7FFF, 32'h8000_7FF0, 0};
        tab[4] = '{16'h1234, 16'h5678, 32'h1234_5678, 32'h1230_5670, 300};
        tab[5] = '{16'h0F0F, 16'hF0F0, 32'h0F0F_F0F0, 32'h0F00_F0F0, 0};

        ifA.sample_left  = '0;
        ifA.sample_right = '0;
        ifA.sample_valid = 1'b0;
        ifB.sample_left  = '0;
        ifB.sample_right = '0;
        ifB.sample_valid = 1'b0;

        // Idle after reset: underrun every frame start, silence.
        doReset();
        base = underCnt;
        repeat (300) @(posedge clk);
        #1;
        chkWord("idleUnderruns", 32'(underCnt - base), 32'd3);

        // Table: first pair before the first frame start, then back-to-back.
        doReset();
        for (int i = 0; i < 6; i++) begin
            offer(tab[i].left, tab[i].right, tab[i].expA, tab[i].expB,
                  (tab[i].gap == 0) && (i != 5));
            repeat (tab[i].gap) @(posedge clk);
            #1;
        end
        repeat (300) @(posedge clk);
        #1;
        chkWord("queueDrained", 32'(sbq.size()), 32'd0);

        // Reset at bit 7 of a frame with the holding buffer full.
        doReset();
        offer(16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFF0_FFF0, 1'b0);
        offer(16'h1111, 16'h2222, 32'h1111_2222, 32'h1110_2220, 1'b0);
        waitCnt(34);
        chkBit("preAbortSdA", sdA, 1'b1);
        chkBit("preAbortReadyA", ifA.sample_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chkBit("abortBclkA", bclkA, 1'b0);
        chkBit("abortSdA", sdA, 1'b0);
        chkBit("abortSdB", sdB, 1'b0);
        chkBit("abortLrA", lrA, 1'b0);
        chkBit("abortUrA", urA, 1'b0);
        chkBit("abortReadyA", ifA.sample_ready, 1'b1);
        chkBit("abortReadyB", ifB.sample_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        base = underCnt;

        // Pair accepted exactly at an empty frame start waits one frame.
        waitCnt(131);
        offer(16'h8001, 16'h4002, 32'h8001_4002, 32'h8000_4000, 1'b0);
        waitCnt(140);
        chkWord("abortUnderruns", 32'(underCnt - base), 32'd2);
        repeat (300) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
